// File: rtl/jt51_kon_pkg.sv
// rtl/jt51_kon_pkg.sv - shared types and constants for the jt51 key-on scheduler
package jt51_kon_pkg;

    localparam int KON_CH_W = 3;
    localparam int KON_OP_W = 4;

    // Operator bit positions inside the 4-bit key-on mask {S4,S2,S3,S1}
    localparam int KON_S1 = 0;
    localparam int KON_S3 = 1;
    localparam int KON_S2 = 2;
    localparam int KON_S4 = 3;

    typedef struct packed {
        logic [KON_CH_W-1:0] ch;
        logic [KON_OP_W-1:0] op;
    } kon_cmd_t;

    typedef enum logic {
        KON_IDLE = 1'b0,
        KON_HOLD = 1'b1
    } kon_state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_AUX = 1'b1
    } kon_grant_t;

endpackage

// File: rtl/jt51_kon_fifo.sv
// rtl/jt51_kon_fifo.sv - DEPTH x 7-bit command FIFO with push/pop/level
module jt51_kon_fifo
    import jt51_kon_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  kon_cmd_t      din_i,
    input  logic          pop_i,
    output kon_cmd_t      dout_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [LW-1:0] level_o
);

    kon_cmd_t        mem_q [DEPTH];
    logic [AW-1:0]   wr_q;
    logic [AW-1:0]   rd_q;
    logic [LW-1:0]   level_q;
    logic            do_push;
    logic            do_pop;

    // A pop frees the slot a simultaneous push may take, so push is legal when full if popping
    always_comb begin
        empty_o = (level_q == '0);
        full_o  = (level_q == LW'(DEPTH));
        do_pop  = pop_i & ~empty_o;
        do_push = push_i & (~full_o | do_pop);
        dout_o  = mem_q[rd_q];
        level_o = level_q;
    end

    // Storage array; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/jt51_kon_sched.sv
// rtl/jt51_kon_sched.sv - round-robin key-on command scheduler holding up_keyon one slot round
module jt51_kon_sched
    import jt51_kon_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int HOLD  = 32,
    localparam int LW = $clog2(DEPTH) + 1,
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          cpu_valid,
    input  logic [2:0]    cpu_ch,
    input  logic [3:0]    cpu_op,
    output logic          cpu_ready,
    input  logic          aux_valid,
    input  logic [2:0]    aux_ch,
    input  logic [3:0]    aux_op,
    output logic          aux_ready,
    output logic [2:0]    keyon_ch,
    output logic [3:0]    keyon_op,
    output logic          up_keyon,
    output logic          busy,
    output logic [LW-1:0] level,
    output logic          ovf
);

    kon_state_t      state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      keyon_ch_q;
    logic [3:0]      keyon_op_q;
    logic            up_keyon_q;
    logic            ovf_q;
    logic            ovf_d;
    kon_grant_t      last_grant_q;
    kon_grant_t      last_grant_d;

    logic            fifo_empty;
    logic            fifo_full;
    kon_cmd_t        fifo_head;
    logic [LW-1:0]   fifo_level;
    logic            pop;
    logic            room;
    logic            prefer_cpu;
    logic            cpu_push;
    logic            aux_push;
    logic            push;
    kon_cmd_t        push_cmd;

    jt51_kon_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (push_cmd),
        .pop_i   (pop),
        .dout_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (fifo_level)
    );

    // Arbiter: one push per clk, alternating on contention, room counts a same-clk pop
    always_comb begin
        pop          = (state_q == KON_IDLE) & ~fifo_empty;
        room         = ~rst & (~fifo_full | pop);
        prefer_cpu   = (last_grant_q == GNT_AUX);
        cpu_ready    = room & (~aux_valid | prefer_cpu);
        aux_ready    = room & (~cpu_valid | ~prefer_cpu);
        cpu_push     = cpu_valid & cpu_ready;
        aux_push     = aux_valid & aux_ready;
        push         = cpu_push | aux_push;
        push_cmd     = cpu_push ? kon_cmd_t'({cpu_ch, cpu_op}) : kon_cmd_t'({aux_ch, aux_op});
        last_grant_d = cpu_push ? GNT_CPU : (aux_push ? GNT_AUX : last_grant_q);
        ovf_d        = ovf_q | (~rst & ~room & (cpu_valid | aux_valid));
    end

    // Round-robin pointer and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GNT_AUX;
            ovf_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            ovf_q        <= ovf_d;
        end
    end

    // IDLE/HOLD FSM: pop without waiting for cen, then hold up_keyon for HOLD cen pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= KON_IDLE;
            cnt_q      <= '0;
            keyon_ch_q <= '0;
            keyon_op_q <= '0;
            up_keyon_q <= 1'b0;
        end else begin
            case (state_q)
                KON_IDLE: begin
                    if (pop) begin
                        keyon_ch_q <= fifo_head.ch;
                        keyon_op_q <= fifo_head.op;
                        cnt_q      <= CW'(HOLD - 1);
                        up_keyon_q <= 1'b1;
                        state_q    <= KON_HOLD;
                    end
                end
                KON_HOLD: begin
                    if (cen) begin
                        if (cnt_q == '0) begin
                            up_keyon_q <= 1'b0;
                            state_q    <= KON_IDLE;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                end
                default: begin
                    up_keyon_q <= 1'b0;
                    state_q    <= KON_IDLE;
                end
            endcase
        end
    end

    // Output mapping; busy covers both queued work and the active hold
    always_comb begin
        keyon_ch = keyon_ch_q;
        keyon_op = keyon_op_q;
        up_keyon = up_keyon_q;
        ovf      = ovf_q;
        level    = fifo_level;
        busy     = (fifo_level != '0) | (state_q == KON_HOLD);
    end

endmodule

// File: tb/tb_jt51_kon_sched.sv
// tb/tb_jt51_kon_sched.sv - self-checking bench for jt51_kon_sched
module tb_jt51_kon_sched;
    import jt51_kon_pkg::*;

    localparam int DEPTH = 4;
    localparam int HOLD  = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b0;
    logic       cpu_valid = 1'b0;
    logic [2:0] cpu_ch = '0;
    logic [3:0] cpu_op = '0;
    logic       cpu_ready;
    logic       aux_valid = 1'b0;
    logic [2:0] aux_ch = '0;
    logic [3:0] aux_op = '0;
    logic       aux_ready;
    logic [2:0] keyon_ch;
    logic [3:0] keyon_op;
    logic       up_keyon;
    logic       busy;
    logic [2:0] level;
    logic       ovf;

    int checks = 0;
    int errors = 0;
    int cen_mode = 0;

    always #5 clk = ~clk;

    jt51_kon_sched #(.DEPTH(DEPTH), .HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .cen(cen),
        .cpu_valid(cpu_valid), .cpu_ch(cpu_ch), .cpu_op(cpu_op), .cpu_ready(cpu_ready),
        .aux_valid(aux_valid), .aux_ch(aux_ch), .aux_op(aux_op), .aux_ready(aux_ready),
        .keyon_ch(keyon_ch), .keyon_op(keyon_op), .up_keyon(up_keyon),
        .busy(busy), .level(level), .ovf(ovf)
    );

    typedef struct {
        logic       cv;
        logic [2:0] cch;
        logic [3:0] cop;
        logic       av;
        logic [2:0] ach;
        logic [3:0] aop;
        logic       exp_cr;
        logic       exp_ar;
        logic       exp_up;
        logic [2:0] exp_lvl;
        logic [2:0] exp_kch;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        case (cen_mode)
            0:       cen = 1'b0;
            1:       cen = 1'b1;
            default: cen = ~cen;
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cpu_valid = 1'b0;
        aux_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_up(input string name);
        int guard = 0;
        while (!up_keyon && guard < 200) begin
            tick();
            guard++;
        end
        check(name, up_keyon, 1);
    endtask

    task automatic count_hold(output int n);
        int guard = 0;
        n = 0;
        while (up_keyon && guard < 5000) begin
            if (cen) n++;
            tick();
            guard++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [3:0] all_ops;
        kon_cmd_t q[$];
        kon_cmd_t c_cmd, a_cmd, popped;
        bit cpend, apend, m_hold, m_ovf, m_last_cpu, m_pop, m_room;
        int m_rem, g;
        logic [2:0] m_ch;
        logic [3:0] m_op;

        tbl[0] = '{1'b1, 3'd1, 4'd1, 1'b1, 3'd2, 4'd2, 1'b1, 1'b0, 1'b0, 3'd1, 3'd0};
        tbl[1] = '{1'b1, 3'd1, 4'd1, 1'b1, 3'd2, 4'd2, 1'b0, 1'b1, 1'b1, 3'd1, 3'd1};
        tbl[2] = '{1'b1, 3'd1, 4'd1, 1'b1, 3'd2, 4'd2, 1'b1, 1'b0, 1'b1, 3'd2, 3'd1};
        tbl[3] = '{1'b1, 3'd1, 4'd1, 1'b1, 3'd2, 4'd2, 1'b0, 1'b1, 1'b1, 3'd3, 3'd1};
        tbl[4] = '{1'b0, 3'd0, 4'd0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1, 3'd3, 3'd1};

        // Reset with requests pending
        rst = 1'b1; cpu_valid = 1'b1; cpu_ch = 3'd3; cpu_op = 4'h7;
        aux_valid = 1'b1; aux_ch = 3'd4; aux_op = 4'h2;
        tick(); tick(); tick();
        check("rst_up", up_keyon, 0);
        check("rst_kch", keyon_ch, 0);
        check("rst_kop", keyon_op, 0);
        check("rst_busy", busy, 0);
        check("rst_level", level, 0);
        check("rst_ovf", ovf, 0);
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_aux_ready", aux_ready, 0);
        aux_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("rel_cpu_ready", cpu_ready, 1);
        cpu_valid = 1'b0;
        tick();
        check("rel_level", level, 0);

        // Single command, cen every second clk
        do_reset();
        cen_mode = 2;
        all_ops = '0;
        all_ops[KON_S1] = 1'b1; all_ops[KON_S2] = 1'b1;
        all_ops[KON_S3] = 1'b1; all_ops[KON_S4] = 1'b1;
        cpu_valid = 1'b1; cpu_ch = 3'd5; cpu_op = all_ops;
        #1;
        check("single_ready", cpu_ready, 1);
        tick();
        cpu_valid = 1'b0;
        check("single_up_push_clk", up_keyon, 0);
        check("single_busy_push_clk", busy, 1);
        tick();
        check("single_up", up_keyon, 1);
        check("single_kch", keyon_ch, 5);
        check("single_kop", keyon_op, 4'hF);
        count_hold(n);
        check("single_cen_pulses", n, HOLD);
        check("single_up_fall", up_keyon, 0);
        check("single_busy_fall", busy, 0);
        check("single_kch_kept", keyon_ch, 5);

        // Arbitration table, cen held low so the first command stays in HOLD
        do_reset();
        cen_mode = 0; cen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cpu_valid = tbl[i].cv; cpu_ch = tbl[i].cch; cpu_op = tbl[i].cop;
            aux_valid = tbl[i].av; aux_ch = tbl[i].ach; aux_op = tbl[i].aop;
            #1;
            if (tbl[i].cv) check($sformatf("arb%0d_cpu_ready", i), cpu_ready, tbl[i].exp_cr);
            if (tbl[i].av) check($sformatf("arb%0d_aux_ready", i), aux_ready, tbl[i].exp_ar);
            @(posedge clk);
            #1;
            check($sformatf("arb%0d_up", i), up_keyon, tbl[i].exp_up);
            check($sformatf("arb%0d_level", i), level, tbl[i].exp_lvl);
            check($sformatf("arb%0d_kch", i), keyon_ch, tbl[i].exp_kch);
        end
        cpu_valid = 1'b0; aux_valid = 1'b0;
        cen_mode = 1; cen = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_up($sformatf("order%0d_up", k));
            check($sformatf("order%0d_kch", k), keyon_ch, (k % 2 == 0) ? 1 : 2);
            check($sformatf("order%0d_kop", k), keyon_op, (k % 2 == 0) ? 1 : 2);
            count_hold(n);
            check($sformatf("order%0d_pulses", k), n, HOLD);
            check($sformatf("order%0d_gap", k), up_keyon, 0);
        end
        check("order_busy_end", busy, 0);

        // Fill to overflow with cen stuck low
        do_reset();
        cen_mode = 0; cen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cpu_valid = 1'b1; cpu_ch = 3'(i); cpu_op = 4'(i + 1);
            #1;
            check($sformatf("fill%0d_ready", i), cpu_ready, 1);
            @(posedge clk);
            #1;
        end
        check("fill_level", level, 4);
        check("fill_up", up_keyon, 1);
        check("fill_kch", keyon_ch, 0);
        check("fill_ovf_clear", ovf, 0);
        cpu_ch = 3'd5; cpu_op = 4'd6;
        #1;
        check("full_ready", cpu_ready, 0);
        @(posedge clk);
        #1;
        check("full_ovf", ovf, 1);
        check("full_level", level, 4);

        // Push and pop in the same clk once the hold ends
        cen_mode = 1; cen = 1'b1;
        count_hold(n);
        check("pp_pulses", n, HOLD);
        check("pp_level_before", level, 4);
        check("pp_ready", cpu_ready, 1);
        tick();
        cpu_valid = 1'b0;
        check("pp_level_after", level, 4);
        check("pp_up", up_keyon, 1);
        check("pp_kch", keyon_ch, 1);
        check("pp_kop", keyon_op, 2);
        check("pp_ovf_sticky", ovf, 1);

        // Reset in the middle of a hold (counter at 10)
        repeat (21) tick();
        check("midrst_up_before", up_keyon, 1);
        rst = 1'b1; cpu_valid = 1'b1; cpu_ch = 3'd7; cpu_op = 4'hA;
        tick();
        check("midrst_up", up_keyon, 0);
        check("midrst_busy", busy, 0);
        check("midrst_level", level, 0);
        check("midrst_ovf", ovf, 0);
        rst = 1'b0;
        #1;
        check("midrst_ready", cpu_ready, 1);
        tick();
        cpu_valid = 1'b0;
        check("midrst_up_push_clk", up_keyon, 0);
        tick();
        check("midrst_up_new", up_keyon, 1);
        check("midrst_kch_new", keyon_ch, 7);
        check("midrst_kop_new", keyon_op, 4'hA);
        count_hold(n);
        check("midrst_pulses", n, HOLD);

        // Randomised traffic against a queue-based reference model
        do_reset();
        cen_mode = 0;
        q.delete();
        cpend = 0; apend = 0; m_hold = 0; m_ovf = 0; m_last_cpu = 0;
        m_rem = 0; m_ch = '0; m_op = '0;
        c_cmd = '0; a_cmd = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!cpend && $urandom_range(0, 2) == 0) begin
                cpend = 1; c_cmd = kon_cmd_t'($urandom_range(0, 127));
            end
            if (!apend && $urandom_range(0, 2) == 0) begin
                apend = 1; a_cmd = kon_cmd_t'($urandom_range(0, 127));
            end
            cpu_valid = cpend; cpu_ch = c_cmd.ch; cpu_op = c_cmd.op;
            aux_valid = apend; aux_ch = a_cmd.ch; aux_op = a_cmd.op;
            if ((i % 600) < 120) cen = 1'b0;
            else cen = ($urandom_range(0, 3) != 0);
            #1;
            m_pop  = !m_hold && (q.size() > 0);
            m_room = (q.size() < DEPTH) || m_pop;
            g = 0;
            if (m_room) begin
                if (cpend && apend) g = m_last_cpu ? 2 : 1;
                else if (cpend) g = 1;
                else if (apend) g = 2;
            end
            if (cpend) check("rnd_cpu_ready", cpu_ready, (g == 1));
            if (apend) check("rnd_aux_ready", aux_ready, (g == 2));
            if (!m_room && (cpend || apend)) m_ovf = 1;
            @(posedge clk);
            if (m_pop) begin
                popped = q.pop_front();
                m_ch = popped.ch; m_op = popped.op;
                m_hold = 1; m_rem = HOLD;
            end else if (m_hold && cen) begin
                m_rem--;
                if (m_rem == 0) m_hold = 0;
            end
            if (g == 1) begin
                q.push_back(c_cmd); m_last_cpu = 1; cpend = 0;
            end else if (g == 2) begin
                q.push_back(a_cmd); m_last_cpu = 0; apend = 0;
            end
            #1;
            check("rnd_up", up_keyon, m_hold);
            check("rnd_kch", keyon_ch, m_ch);
            check("rnd_kop", keyon_op, m_op);
            check("rnd_level", level, q.size());
            check("rnd_busy", busy, (q.size() > 0) || m_hold);
            check("rnd_ovf", ovf, m_ovf);
        end
        cpu_valid = 1'b0; aux_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
